// File: rtl/if_pc_fetch.sv
// ---------------------------------------------------------------------------
// if_pc_fetch
// Instruction-fetch front end. Owns the program counter, requests words from
// instruction memory over a req/ready handshake, and loads the IF/ID pipeline
// register with the fetched instruction and its PC+4. A taken branch (from the
// ID-stage target adder) or a decoded jump redirects fetch.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   stall             hazard unit request to freeze PC and IF/ID
//   branch_taken      redirect to pc_target (wins over jump)
//   pc_target         branch target address
//   jump, jump_addr   redirect to jump_addr
//   imem_req          fetch request valid
//   imem_addr         fetch address
//   imem_ready        memory returns imem_rdata this cycle
//   imem_rdata        instruction word from memory
//   pc                current fetch PC
//   if_id_valid       IF/ID holds a live instruction
//   if_id_instr       IF/ID instruction word
//   if_id_pc_next     PC+4 of the IF/ID instruction
// ---------------------------------------------------------------------------
module if_pc_fetch #(
   parameter int                 WIDTH_I  = 32,
   parameter logic [WIDTH_I-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               stall,
   input  logic               branch_taken,
   input  logic [WIDTH_I-1:0] pc_target,
   input  logic               jump,
   input  logic [WIDTH_I-1:0] jump_addr,
   output logic               imem_req,
   output logic [WIDTH_I-1:0] imem_addr,
   input  logic               imem_ready,
   input  logic [WIDTH_I-1:0] imem_rdata,
   output logic [WIDTH_I-1:0] pc,
   output logic               if_id_valid,
   output logic [WIDTH_I-1:0] if_id_instr,
   output logic [WIDTH_I-1:0] if_id_pc_next
);

   typedef enum logic [1:0] {
      ST_BOOT,
      ST_FETCH,
      ST_DISCARD
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH_I-1:0] pc_q, pc_d;
   logic [WIDTH_I-1:0] held_addr_q, held_addr_d;
   logic               valid_q, valid_d;
   logic [WIDTH_I-1:0] instr_q, instr_d;
   logic [WIDTH_I-1:0] pc_next_q, pc_next_d;

   logic               redirect;
   logic [WIDTH_I-1:0] redirect_src;
   logic [WIDTH_I-1:0] redirect_addr;
   logic [WIDTH_I-1:0] pc_plus4;
   logic               transfer;

   // Branch belongs to the older instruction, so it wins over a jump.
   // Redirect targets are forced word aligned.
   assign redirect      = branch_taken | jump;
   assign redirect_src  = branch_taken ? pc_target : jump_addr;
   assign redirect_addr = redirect_src & ~WIDTH_I'(3);
   assign pc_plus4      = pc_q + WIDTH_I'(4);
   assign transfer      = imem_req & imem_ready;

   // Request decode. In DISCARD the abandoned request must stay on the bus
   // unchanged until memory accepts it, regardless of stall.
   always_comb begin
      imem_req  = 1'b0;
      imem_addr = pc_q;
      case (state_q)
         ST_FETCH:   imem_req = !stall;
         ST_DISCARD: begin
            imem_req  = 1'b1;
            imem_addr = held_addr_q;
         end
         default:    imem_req = 1'b0;
      endcase
   end

   // Next-state and register update. Priority in FETCH is
   // redirect > stall > transfer > bubble.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      held_addr_d = held_addr_q;
      valid_d     = valid_q;
      instr_d     = instr_q;
      pc_next_d   = pc_next_q;
      case (state_q)
         ST_BOOT: begin
            state_d = ST_FETCH;
            if (redirect) pc_d = redirect_addr;
         end
         ST_FETCH: begin
            if (redirect) begin
               pc_d    = redirect_addr;
               valid_d = 1'b0;
               // An outstanding request cannot be withdrawn; park its address
               // and sink the response before fetching the new target.
               if (imem_req && !imem_ready) begin
                  held_addr_d = pc_q;
                  state_d     = ST_DISCARD;
               end
            end else if (stall) begin
               state_d = ST_FETCH;
            end else if (transfer) begin
               instr_d   = imem_rdata;
               pc_next_d = pc_plus4;
               valid_d   = 1'b1;
               pc_d      = pc_plus4;
            end else begin
               valid_d = 1'b0;
            end
         end
         ST_DISCARD: begin
            valid_d = 1'b0;
            if (redirect) pc_d = redirect_addr;
            if (imem_ready) state_d = ST_FETCH;
         end
         default: state_d = ST_BOOT;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_BOOT;
         pc_q        <= RESET_PC;
         held_addr_q <= RESET_PC;
         valid_q     <= 1'b0;
         instr_q     <= '0;
         pc_next_q   <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         held_addr_q <= held_addr_d;
         valid_q     <= valid_d;
         instr_q     <= instr_d;
         pc_next_q   <= pc_next_d;
      end
   end

   assign pc            = pc_q;
   assign if_id_valid   = valid_q;
   assign if_id_instr   = instr_q;
   assign if_id_pc_next = pc_next_q;

endmodule

// File: tb/tb_if_pc_fetch.sv
// ---------------------------------------------------------------------------
// tb_if_pc_fetch
// Self-checking bench for if_pc_fetch. Inputs change on the falling edge and
// outputs are sampled away from the rising edge. Every accepted fetch pushes
// its expected {instruction, PC+4} into a scoreboard queue that is popped when
// IF/ID shows the instruction.
// ---------------------------------------------------------------------------
module tb_if_pc_fetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic        branch_taken;
   logic [31:0] pc_target;
   logic        jump;
   logic [31:0] jump_addr;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] pc;
   logic        if_id_valid;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc_next;

   int          checks   = 0;
   int          failures = 0;
   logic [63:0] sb_q[$];
   logic [31:0] exp_pc;
   logic [31:0] last_instr;
   logic [31:0] last_pc_next;

   if_pc_fetch #(.WIDTH_I(32), .RESET_PC(32'h0000_0000)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .stall        (stall),
      .branch_taken (branch_taken),
      .pc_target    (pc_target),
      .jump         (jump),
      .jump_addr    (jump_addr),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ready   (imem_ready),
      .imem_rdata   (imem_rdata),
      .pc           (pc),
      .if_id_valid  (if_id_valid),
      .if_id_instr  (if_id_instr),
      .if_id_pc_next(if_id_pc_next)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // Instruction memory contents: a distinct word derived from each address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0] ^ 16'hBEEF, ~a[15:0]};
   endfunction

   assign imem_rdata = mem_word(imem_addr);

   // Release to BOOT, then stream n zero-wait fetches from exp_pc.
   task automatic test_boot_stream(input int n);
      logic [63:0] e;
      #1;
      checks++;
      if (imem_req !== 1'b0) begin
         failures++;
         $display("[TB] FAIL boot_req: got %b expected 0", imem_req);
      end
      @(negedge clk);
      for (int i = 0; i < n; i++) begin
         #1;
         checks++;
         if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin
            failures++;
            $display("[TB] FAIL stream_addr: got req=%b addr=%h expected req=1 addr=%h",
                     imem_req, imem_addr, exp_pc);
         end
         sb_q.push_back({mem_word(exp_pc), exp_pc + 32'd4});
         exp_pc = exp_pc + 32'd4;
         @(negedge clk);
         checks++;
         if (sb_q.size() == 0) begin
            failures++;
            $display("[TB] FAIL stream_sb: scoreboard empty");
         end else begin
            e = sb_q.pop_front();
            last_instr   = e[63:32];
            last_pc_next = e[31:0];
            if (if_id_valid !== 1'b1 || if_id_instr !== e[63:32] ||
                if_id_pc_next !== e[31:0] || pc !== exp_pc) begin
               failures++;
               $display("[TB] FAIL stream_ifid: got v=%b instr=%h pcn=%h pc=%h expected v=1 instr=%h pcn=%h pc=%h",
                        if_id_valid, if_id_instr, if_id_pc_next, pc, e[63:32], e[31:0], exp_pc);
            end
         end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
      pc_target = '0; jump_addr = '0; imem_ready = 1'b1;
      #3;
      checks++;
      if (pc !== 32'h0 || imem_req !== 1'b0 || imem_addr !== 32'h0 ||
          if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || if_id_pc_next !== 32'h0) begin
         failures++;
         $display("[TB] FAIL reset_vals: got pc=%h req=%b addr=%h v=%b instr=%h pcn=%h expected all zero",
                  pc, imem_req, imem_addr, if_id_valid, if_id_instr, if_id_pc_next);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n  = 1'b1;
      exp_pc = 32'h0;
      test_boot_stream(4);
   endtask

   task automatic test_stall;
      logic [63:0] e;
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (imem_req !== 1'b0) begin
            failures++;
            $display("[TB] FAIL stall_req: got %b expected 0", imem_req);
         end
         @(negedge clk);
         checks++;
         if (pc !== exp_pc || if_id_valid !== 1'b1 || if_id_instr !== last_instr ||
             if_id_pc_next !== last_pc_next) begin
            failures++;
            $display("[TB] FAIL stall_hold: got pc=%h v=%b instr=%h pcn=%h expected pc=%h v=1 instr=%h pcn=%h",
                     pc, if_id_valid, if_id_instr, if_id_pc_next, exp_pc, last_instr, last_pc_next);
         end
      end
      stall = 1'b0;
      #1;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin
         failures++;
         $display("[TB] FAIL stall_resume: got req=%b addr=%h expected req=1 addr=%h",
                  imem_req, imem_addr, exp_pc);
      end
      sb_q.push_back({mem_word(exp_pc), exp_pc + 32'd4});
      exp_pc = exp_pc + 32'd4;
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if (if_id_valid !== 1'b1 || if_id_instr !== e[63:32] || if_id_pc_next !== e[31:0]) begin
         failures++;
         $display("[TB] FAIL stall_resume_ifid: got v=%b instr=%h pcn=%h expected v=1 instr=%h pcn=%h",
                  if_id_valid, if_id_instr, if_id_pc_next, e[63:32], e[31:0]);
      end
   endtask

   // Branch and jump together: branch wins, fetched word is dropped.
   task automatic test_redirect_priority;
      logic [63:0] e;
      branch_taken = 1'b1; pc_target = 32'h0000_0100;
      jump = 1'b1; jump_addr = 32'h0000_0200;
      imem_ready = 1'b1;
      @(negedge clk);
      branch_taken = 1'b0; jump = 1'b0;
      exp_pc = 32'h0000_0100;
      #1;
      checks++;
      if (if_id_valid !== 1'b0 || pc !== exp_pc || imem_addr !== exp_pc || imem_req !== 1'b1) begin
         failures++;
         $display("[TB] FAIL redirect_prio: got v=%b pc=%h addr=%h req=%b expected v=0 pc=%h addr=%h req=1",
                  if_id_valid, pc, imem_addr, imem_req, exp_pc, exp_pc);
      end
      sb_q.push_back({mem_word(exp_pc), exp_pc + 32'd4});
      exp_pc = exp_pc + 32'd4;
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if (if_id_valid !== 1'b1 || if_id_instr !== e[63:32] || if_id_pc_next !== e[31:0]) begin
         failures++;
         $display("[TB] FAIL redirect_first: got v=%b instr=%h pcn=%h expected v=1 instr=%h pcn=%h",
                  if_id_valid, if_id_instr, if_id_pc_next, e[63:32], e[31:0]);
      end
   endtask

   // Redirect while a request to 0x10 is still waiting on memory.
   task automatic test_discard;
      logic [63:0] e;
      jump = 1'b1; jump_addr = 32'h0000_0010; imem_ready = 1'b1;
      @(negedge clk);
      jump = 1'b0;
      imem_ready = 1'b0;
      branch_taken = 1'b1; pc_target = 32'h0000_0040;
      #1;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
         failures++;
         $display("[TB] FAIL discard_entry: got req=%b addr=%h expected req=1 addr=00000010",
                  imem_req, imem_addr);
      end
      @(negedge clk);
      branch_taken = 1'b0;
      for (int i = 0; i < 2; i++) begin
         stall = (i == 1);
         #1;
         checks++;
         if (imem_req !== 1'b1 || imem_addr !== 32'h10 || if_id_valid !== 1'b0 || pc !== 32'h40) begin
            failures++;
            $display("[TB] FAIL discard_hold: got req=%b addr=%h v=%b pc=%h expected req=1 addr=00000010 v=0 pc=00000040",
                     imem_req, imem_addr, if_id_valid, pc);
         end
         @(negedge clk);
      end
      stall = 1'b0;
      imem_ready = 1'b1;
      @(negedge clk);
      #1;
      checks++;
      if (if_id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
         failures++;
         $display("[TB] FAIL discard_exit: got v=%b req=%b addr=%h expected v=0 req=1 addr=00000040",
                  if_id_valid, imem_req, imem_addr);
      end
      exp_pc = 32'h40;
      sb_q.push_back({mem_word(exp_pc), exp_pc + 32'd4});
      exp_pc = exp_pc + 32'd4;
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if (if_id_valid !== 1'b1 || if_id_instr !== e[63:32] || if_id_pc_next !== e[31:0]) begin
         failures++;
         $display("[TB] FAIL discard_target: got v=%b instr=%h pcn=%h expected v=1 instr=%h pcn=%h",
                  if_id_valid, if_id_instr, if_id_pc_next, e[63:32], e[31:0]);
      end
   endtask

   task automatic test_wrap;
      logic [63:0] e;
      jump = 1'b1; jump_addr = 32'hFFFF_FFFC;
      @(negedge clk);
      jump = 1'b0;
      sb_q.push_back({mem_word(32'hFFFF_FFFC), 32'h0});
      @(negedge clk);
      #1;
      e = sb_q.pop_front();
      checks++;
      if (if_id_valid !== 1'b1 || if_id_instr !== e[63:32] || if_id_pc_next !== e[31:0] ||
          pc !== 32'h0 || imem_addr !== 32'h0) begin
         failures++;
         $display("[TB] FAIL wrap: got v=%b instr=%h pcn=%h pc=%h addr=%h expected v=1 instr=%h pcn=00000000 pc=0 addr=0",
                  if_id_valid, if_id_instr, if_id_pc_next, pc, imem_addr, e[63:32]);
      end
   endtask

   // Asynchronous reset in the middle of a DISCARD, then re-boot and check
   // that an unaligned jump is forced to a word boundary.
   task automatic test_async_reset;
      logic [63:0] e;
      imem_ready = 1'b0;
      jump = 1'b1; jump_addr = 32'h0000_0500;
      @(negedge clk);
      jump = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (pc !== 32'h0 || imem_req !== 1'b0 || imem_addr !== 32'h0 ||
          if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || if_id_pc_next !== 32'h0) begin
         failures++;
         $display("[TB] FAIL async_reset: got pc=%h req=%b addr=%h v=%b instr=%h pcn=%h expected all zero",
                  pc, imem_req, imem_addr, if_id_valid, if_id_instr, if_id_pc_next);
      end
      @(negedge clk);
      rst_n = 1'b1;
      imem_ready = 1'b1;
      exp_pc = 32'h0;
      test_boot_stream(2);
      jump = 1'b1; jump_addr = 32'h0000_0123;
      @(negedge clk);
      jump = 1'b0;
      #1;
      checks++;
      if (pc !== 32'h120 || imem_addr !== 32'h120 || if_id_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL jump_align: got pc=%h addr=%h v=%b expected pc=00000120 addr=00000120 v=0",
                  pc, imem_addr, if_id_valid);
      end
      sb_q.push_back({mem_word(32'h120), 32'h124});
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if (if_id_valid !== 1'b1 || if_id_instr !== e[63:32] || if_id_pc_next !== e[31:0]) begin
         failures++;
         $display("[TB] FAIL jump_fetch: got v=%b instr=%h pcn=%h expected v=1 instr=%h pcn=%h",
                  if_id_valid, if_id_instr, if_id_pc_next, e[63:32], e[31:0]);
      end
   endtask

   // Test sequence.
   initial begin
      @(negedge clk);
      test_reset();
      test_stall();
      test_redirect_priority();
      test_discard();
      test_wrap();
      test_async_reset();
      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("[TB] FAIL sb_drain: got %0d entries left expected 0", sb_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
